// File: rtl/mining_job_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : mining_job_loader_if
// Brief    : Header stream, miner control and result record bundle for the
//            mining job loader.
// Revision : 1.0
// ============================================================================
interface mining_job_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [31:0]  cfg_max_nonce;

  logic [639:0] header_template;
  logic [255:0] target;
  logic [31:0]  max_nonce;

  logic         miner_start;
  logic         miner_busy;
  logic         miner_found;
  logic         miner_exhausted;
  logic [31:0]  miner_nonce;

  logic         res_valid;
  logic         res_ready;
  logic         res_found;
  logic         res_error;
  logic [31:0]  res_nonce;

  // Loader side
  modport slave (
    input  in_valid, in_data, in_last, cfg_max_nonce,
    input  miner_busy, miner_found, miner_exhausted, miner_nonce,
    input  res_ready,
    output in_ready, header_template, target, max_nonce, miner_start,
    output res_valid, res_found, res_error, res_nonce
  );

  // Environment side: header source, miner and result consumer
  modport master (
    output in_valid, in_data, in_last, cfg_max_nonce,
    output miner_busy, miner_found, miner_exhausted, miner_nonce,
    output res_ready,
    input  in_ready, header_template, target, max_nonce, miner_start,
    input  res_valid, res_found, res_error, res_nonce
  );
endinterface
`default_nettype wire

// File: rtl/mining_job_loader.sv
`default_nettype none
// ============================================================================
// Module   : mining_job_loader
// Brief    : Assembles a 20-word block header, expands nBits into the 256-bit
//            target, launches the miner and holds one result record.
// Revision : 1.0
// ============================================================================
module mining_job_loader (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mining_job_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_EXPAND = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [4:0] c_last_word = 5'd19;

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic [4:0]   r_word_cnt;
  logic [639:0] r_header;
  logic [255:0] r_target;
  logic [31:0]  r_max_nonce;
  logic         r_res_found;
  logic         r_res_error;
  logic [31:0]  r_res_nonce;

  logic         w_in_ready;
  logic         w_miner_start;
  logic         w_res_valid;
  logic         w_accept;
  logic         w_at_last;
  logic         w_frame_err;
  logic         w_frame_done;
  logic [31:0]  w_nbits;
  logic [7:0]   w_exp;
  logic [22:0]  w_mant;
  logic [279:0] w_mant_wide;
  logic [279:0] w_expanded;
  logic         w_nbits_err;
  logic         w_unused_busy;

  assign w_unused_busy = bus.miner_busy;

  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_at_last    = (r_word_cnt == c_last_word);
  assign w_frame_err  = w_accept && (bus.in_last != w_at_last);
  assign w_frame_done = w_accept && bus.in_last && w_at_last;

  // nBits is little-endian inside the header: word 18 byte-swapped
  assign w_nbits     = {r_header[39:32], r_header[47:40], r_header[55:48], r_header[63:56]};
  assign w_exp       = w_nbits[31:24];
  assign w_mant      = w_nbits[22:0];
  assign w_mant_wide = {257'd0, w_mant};

  always_comb begin
    w_expanded = '0;
    if (w_exp >= 8'd3)
      w_expanded = w_mant_wide << {w_exp - 8'd3, 3'b000};
    else
      w_expanded = w_mant_wide >> (5'd24 - {w_exp[1:0], 3'b000});
  end

  // Exponents above 34 shift a nonzero mantissa wholly past bit 255
  assign w_nbits_err = w_nbits[23] || (w_mant == 23'd0) ||
                       (|w_expanded[279:256]) || (w_exp > 8'd34);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_frame_err)       w_next = S_DONE;
        else if (w_frame_done) w_next = S_EXPAND;
        else if (w_accept)     w_next = S_LOAD;
      end
      S_EXPAND: w_next = w_nbits_err ? S_DONE : S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (bus.miner_found || bus.miner_exhausted) w_next = S_DONE;
      S_DONE:   if (bus.res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready    = 1'b0;
    w_miner_start = 1'b0;
    w_res_valid   = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: w_in_ready    = 1'b1;
      S_LAUNCH:       w_miner_start = 1'b1;
      S_DONE:         w_res_valid   = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_word_cnt <= (w_at_last || bus.in_last) ? 5'd0 : r_word_cnt + 5'd1;
    end
  end

  // Slot 19 holds the nonce field, which the miner owns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_header <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 20; i++) begin
        if (r_word_cnt == 5'(i))
          r_header[639-32*i -: 32] <= (i == 19) ? 32'd0 : bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_nonce <= '0;
      r_target    <= '0;
    end else begin
      if (w_accept && w_at_last)
        r_max_nonce <= bus.cfg_max_nonce;
      if (r_state == S_EXPAND)
        r_target <= w_expanded[255:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_found <= 1'b0;
      r_res_error <= 1'b0;
      r_res_nonce <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: if (w_frame_err) r_res_error <= 1'b1;
        S_EXPAND:       if (w_nbits_err) r_res_error <= 1'b1;
        S_WAIT: begin
          if (bus.miner_found) begin
            r_res_found <= 1'b1;
            r_res_nonce <= bus.miner_nonce;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_found <= 1'b0;
            r_res_error <= 1'b0;
            r_res_nonce <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.miner_start     = w_miner_start;
  assign bus.res_valid       = w_res_valid;
  assign bus.res_found       = r_res_found;
  assign bus.res_error       = r_res_error;
  assign bus.res_nonce       = r_res_nonce;
  assign bus.header_template = r_header;
  assign bus.target          = r_target;
  assign bus.max_nonce       = r_max_nonce;

endmodule
`default_nettype wire

// File: tb/tb_mining_job_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mining_job_loader
// Brief    : Directed self-checking bench for mining_job_loader.
// Revision : 1.0
// ============================================================================
module tb_mining_job_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mining_job_loader_if bus_if ();

  mining_job_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_pass  = 0;
  int n_total = 0;
  int starts  = 0;
  int s0;

  logic [31:0]  hdr [0:19];
  logic [639:0] exp_tpl;

  always @(posedge clk) if (bus_if.miner_start === 1'b1) starts++;

  task automatic build_header(input logic [31:0] w18, input logic [31:0] seed);
    for (int i = 0; i < 20; i++) hdr[i] = seed + 32'(i) * 32'h01010101;
    hdr[18] = w18;
    hdr[19] = 32'hdeadbeef;
    exp_tpl = '0;
    for (int i = 0; i < 19; i++) exp_tpl[639-32*i -: 32] = hdr[i];
  endtask

  task automatic send(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = hdr[i];
      bus_if.in_last  = (i == last_at);
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
    bus_if.in_data  = '0;
  endtask

  task automatic consume();
    bus_if.res_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); else n_pass++;
    n_total++; if (bus_if.miner_start !== 1'b0) $display("FAIL reset_miner_start: got %b want 0", bus_if.miner_start); else n_pass++;
    n_total++; if ({bus_if.res_valid, bus_if.res_found, bus_if.res_error} !== 3'b000)
      $display("FAIL reset_res_flags: got %b want 000", {bus_if.res_valid, bus_if.res_found, bus_if.res_error}); else n_pass++;
    n_total++; if (bus_if.res_nonce !== 32'd0) $display("FAIL reset_res_nonce: got %h want 0", bus_if.res_nonce); else n_pass++;
    n_total++; if (bus_if.header_template !== 640'd0 || bus_if.target !== 256'd0 || bus_if.max_nonce !== 32'd0)
      $display("FAIL reset_job_regs: got tgt %h max %h want zeros", bus_if.target, bus_if.max_nonce); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (dut.r_word_cnt !== 5'd0) $display("FAIL reset_word_cnt: got %0d want 0", dut.r_word_cnt); else n_pass++;
  endtask

  task automatic test_difficulty1();
    build_header(32'hffff001d, 32'h20000000);
    bus_if.cfg_max_nonce = 32'h0000ffff;
    s0 = starts;
    send(20, 19);
    n_total++; if ({bus_if.in_ready, bus_if.miner_start} !== 2'b00)
      $display("FAIL d1_expand_cycle: got rdy/start %b want 00", {bus_if.in_ready, bus_if.miner_start}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus_if.miner_start !== 1'b1) $display("FAIL d1_start_latency: got %b want 1", bus_if.miner_start); else n_pass++;
    n_total++; if (bus_if.target !== {32'h0, 16'hffff, 208'h0})
      $display("FAIL d1_target: got %h want %h", bus_if.target, {32'h0, 16'hffff, 208'h0}); else n_pass++;
    n_total++; if (bus_if.header_template[31:0] !== 32'd0)
      $display("FAIL d1_nonce_zero: got %h want 0", bus_if.header_template[31:0]); else n_pass++;
    n_total++; if (bus_if.header_template !== exp_tpl) $display("FAIL d1_template: got %h want %h", bus_if.header_template[639:320], exp_tpl[639:320]); else n_pass++;
    n_total++; if (bus_if.max_nonce !== 32'h0000ffff) $display("FAIL d1_max_nonce: got %h want 0000ffff", bus_if.max_nonce); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus_if.miner_start !== 1'b0) $display("FAIL d1_start_width: got %b want 0", bus_if.miner_start); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (starts - s0 !== 1) $display("FAIL d1_start_count: got %0d want 1", starts - s0); else n_pass++;
  endtask

  task automatic test_back_pressure();
    bus_if.miner_busy = 1'b1;
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = 32'hcafef00d;
    bus_if.in_last    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_total++; if (bus_if.in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b want 0", i, bus_if.in_ready); else n_pass++;
    end
    n_total++; if (dut.r_word_cnt !== 5'd0) $display("FAIL bp_word_cnt: got %0d want 0", dut.r_word_cnt); else n_pass++;
    n_total++; if (bus_if.header_template !== exp_tpl || bus_if.res_valid !== 1'b0)
      $display("FAIL bp_ignored: got res_valid %b tpl_lo %h", bus_if.res_valid, bus_if.header_template[95:0]); else n_pass++;
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic test_found();
    bus_if.res_ready   = 1'b0;
    bus_if.miner_found = 1'b1;
    bus_if.miner_nonce = 32'h12345678;
    @(posedge clk); #1;
    bus_if.miner_found = 1'b0;
    bus_if.miner_busy  = 1'b0;
    bus_if.miner_nonce = 32'hffffffff;
    n_total++; if ({bus_if.res_valid, bus_if.res_found, bus_if.res_error} !== 3'b110)
      $display("FAIL found_flags: got %b want 110", {bus_if.res_valid, bus_if.res_found, bus_if.res_error}); else n_pass++;
    n_total++; if (bus_if.res_nonce !== 32'h12345678) $display("FAIL found_nonce: got %h want 12345678", bus_if.res_nonce); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++; if ({bus_if.res_valid, bus_if.res_found, bus_if.res_nonce} !== {2'b11, 32'h12345678})
        $display("FAIL found_hold_%0d: got v%b f%b n%h want v1 f1 n12345678", i, bus_if.res_valid, bus_if.res_found, bus_if.res_nonce); else n_pass++;
    end
    n_total++; if (bus_if.header_template !== exp_tpl) $display("FAIL found_tpl_stable: got %h", bus_if.header_template[95:0]); else n_pass++;
    consume();
    n_total++; if ({bus_if.res_valid, bus_if.in_ready} !== 2'b01)
      $display("FAIL found_to_idle: got valid/ready %b want 01", {bus_if.res_valid, bus_if.in_ready}); else n_pass++;
  endtask

  task automatic test_ignored_event();
    bus_if.miner_found     = 1'b1;
    bus_if.miner_exhausted = 1'b1;
    @(posedge clk); #1;
    bus_if.miner_found     = 1'b0;
    bus_if.miner_exhausted = 1'b0;
    n_total++; if ({bus_if.res_valid, bus_if.in_ready} !== 2'b01)
      $display("FAIL idle_event_ignored: got valid/ready %b want 01", {bus_if.res_valid, bus_if.in_ready}); else n_pass++;
  endtask

  task automatic test_small_exp();
    build_header(32'h00800002, 32'h30000000);
    bus_if.cfg_max_nonce = 32'h00000100;
    send(20, 19);
    @(posedge clk); #1;
    n_total++; if (bus_if.miner_start !== 1'b1) $display("FAIL se_start: got %b want 1", bus_if.miner_start); else n_pass++;
    n_total++; if (bus_if.target !== 256'h80) $display("FAIL se_target: got %h want 80", bus_if.target); else n_pass++;
    @(posedge clk); #1;
    bus_if.miner_exhausted = 1'b1;
    bus_if.miner_nonce     = 32'haaaa5555;
    @(posedge clk); #1;
    bus_if.miner_exhausted = 1'b0;
    n_total++; if ({bus_if.res_valid, bus_if.res_found, bus_if.res_error} !== 3'b100)
      $display("FAIL se_exhaust_flags: got %b want 100", {bus_if.res_valid, bus_if.res_found, bus_if.res_error}); else n_pass++;
    n_total++; if (bus_if.res_nonce !== 32'd0) $display("FAIL se_exhaust_nonce: got %h want 0", bus_if.res_nonce); else n_pass++;
    consume();
  endtask

  task automatic test_nbits_errors();
    logic [31:0] words [0:2];
    words[0] = 32'hffff801d;  // nBits 0x1d80ffff: sign bit
    words[1] = 32'h00000122;  // nBits 0x22010000: overflow past bit 255
    words[2] = 32'h0000001d;  // nBits 0x1d000000: zero mantissa
    for (int k = 0; k < 3; k++) begin
      build_header(words[k], 32'h60000000);
      s0 = starts;
      send(20, 19);
      @(posedge clk); #1;
      n_total++; if ({bus_if.res_valid, bus_if.res_found, bus_if.res_error} !== 3'b101)
        $display("FAIL nbits_err_%0d: got %b want 101", k, {bus_if.res_valid, bus_if.res_found, bus_if.res_error}); else n_pass++;
      consume();
      n_total++; if (starts - s0 !== 0) $display("FAIL nbits_no_start_%0d: got %0d starts want 0", k, starts - s0); else n_pass++;
    end
  endtask

  task automatic test_framing();
    build_header(32'hffff001d, 32'h70000000);
    s0 = starts;
    send(6, 5);
    n_total++; if ({bus_if.res_valid, bus_if.res_found, bus_if.res_error, bus_if.in_ready} !== 4'b1010)
      $display("FAIL frame_early_last: got v/f/e/rdy %b want 1010", {bus_if.res_valid, bus_if.res_found, bus_if.res_error, bus_if.in_ready}); else n_pass++;
    n_total++; if (dut.r_word_cnt !== 5'd0) $display("FAIL frame_cnt_clear: got %0d want 0", dut.r_word_cnt); else n_pass++;
    consume();
    send(20, -1);
    n_total++; if ({bus_if.res_valid, bus_if.res_error} !== 2'b11)
      $display("FAIL frame_missing_last: got v/e %b want 11", {bus_if.res_valid, bus_if.res_error}); else n_pass++;
    consume();
    n_total++; if (starts - s0 !== 0) $display("FAIL frame_no_start: got %0d starts want 0", starts - s0); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    build_header(32'hffff001d, 32'h40000000);
    send(10, -1);
    rst_n = 1'b0;
    #2;
    n_total++; if ({bus_if.in_ready, bus_if.miner_start, bus_if.res_valid} !== 3'b100)
      $display("FAIL rml_ctrl: got rdy/start/valid %b want 100", {bus_if.in_ready, bus_if.miner_start, bus_if.res_valid}); else n_pass++;
    n_total++; if (bus_if.header_template !== 640'd0 || bus_if.target !== 256'd0 || bus_if.max_nonce !== 32'd0)
      $display("FAIL rml_job_regs: got tgt %h max %h want zeros", bus_if.target, bus_if.max_nonce); else n_pass++;
    n_total++; if (dut.r_word_cnt !== 5'd0) $display("FAIL rml_word_cnt: got %0d want 0", dut.r_word_cnt); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    build_header(32'hffff001d, 32'h50000000);
    bus_if.cfg_max_nonce = 32'h00000007;
    s0 = starts;
    send(20, 19);
    @(posedge clk); #1;
    n_total++; if (bus_if.miner_start !== 1'b1) $display("FAIL rml_start: got %b want 1", bus_if.miner_start); else n_pass++;
    n_total++; if (bus_if.header_template !== exp_tpl || bus_if.max_nonce !== 32'h7)
      $display("FAIL rml_job: got max %h tpl_hi %h", bus_if.max_nonce, bus_if.header_template[639:576]); else n_pass++;
    @(posedge clk); #1;
    bus_if.miner_exhausted = 1'b1;
    @(posedge clk); #1;
    bus_if.miner_exhausted = 1'b0;
    consume();
    n_total++; if (starts - s0 !== 1) $display("FAIL rml_start_count: got %0d want 1", starts - s0); else n_pass++;
  endtask

  initial begin
    bus_if.in_valid        = 1'b0;
    bus_if.in_data         = '0;
    bus_if.in_last         = 1'b0;
    bus_if.cfg_max_nonce   = '0;
    bus_if.miner_busy      = 1'b0;
    bus_if.miner_found     = 1'b0;
    bus_if.miner_exhausted = 1'b0;
    bus_if.miner_nonce     = '0;
    bus_if.res_ready       = 1'b0;
    #1;
    test_reset();
    test_difficulty1();
    test_back_pressure();
    test_found();
    test_ignored_event();
    test_small_exp();
    test_nbits_errors();
    test_framing();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
